// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//
// Multiplexed 7-segment display driver. Scans NUM_DIGITS digits one at a
// time. Each digit slot lasts 16 scan ticks: the first BLANK_TICKS ticks keep
// every anode off so the previous digit's segments cannot ghost onto the next
// one, and the digit is then lit up to tick brightness_i. Digit values are
// double-buffered (pending -> display at each frame wrap) so a frame never
// mixes old and new values. Also handles decimal points and leading-zero
// suppression.
//
// Ports:
//   clk_i         single clock
//   rst_i         synchronous active-high reset
//   load_i        capture digits_i / digit_en_i / dp_i into the pending buffer
//   digits_i      one hex nibble per digit, digit k at [4k+3:4k]
//   digit_en_i    per-digit enable
//   dp_i          per-digit decimal point
//   brightness_i  PWM level 0..15, used live
//   lzs_en_i      leading-zero suppression enable, used live
//   anode_o       digit select (polarity per ANODE_ACTIVE_LOW)
//   segments_o    bit0=a .. bit6=g (polarity per SEG_ACTIVE_LOW)
//   dp_o          decimal point segment (polarity per SEG_ACTIVE_LOW)
//   frame_o       one-cycle pulse after each frame wrap
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 1,
    parameter int BLANK_TICKS      = 1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [3:0]              brightness_i,
    input  logic                    lzs_en_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              segments_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       BLANK    = 4'(BLANK_TICKS);

    logic [PRE_W-1:0]        pre;
    logic [3:0]              t;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] pend_digits, disp_digits;
    logic [NUM_DIGITS-1:0]   pend_en, disp_en;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;

    logic                    tick;
    logic                    frame_wrap;

    logic [3:0]              cur_val;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_supp;
    logic                    higher_zero;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   anode_ah;
    logic [6:0]              seg_ah;
    logic                    dp_ah;

    // Active-high segment pattern for a hex digit, g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick       = (pre == PRE_LAST);
    assign frame_wrap = tick && (t == 4'hF) && (idx == IDX_LAST);

    // Select the active digit, work out suppression and the lit window.
    // Suppression walks down from the most significant digit: a digit is
    // blanked only while every digit above it (and itself) is zero.
    always_comb begin
        cur_val     = 4'h0;
        cur_en      = 1'b0;
        cur_dp      = 1'b0;
        cur_supp    = 1'b0;
        higher_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_val = disp_digits[4*k +: 4];
                cur_en  = disp_en[k];
                cur_dp  = disp_dp[k];
            end
        end
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            higher_zero = higher_zero && (disp_digits[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) begin
                cur_supp = lzs_en_i && higher_zero;
            end
        end
        lit = (t >= BLANK) && (t <= brightness_i) && cur_en && !cur_supp;
        anode_ah = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_ah[k] = lit && (idx == IDX_W'(k));
        end
        seg_ah = lit ? seg_decode(cur_val) : 7'h00;
        dp_ah  = lit && cur_dp;
    end

    // Scan counters, the two buffers and the registered outputs.
    // A load in the wrap cycle goes straight into the display buffer so
    // it is not delayed by a whole frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre         <= '0;
            t           <= '0;
            idx         <= '0;
            pend_digits <= '0;
            pend_en     <= '0;
            pend_dp     <= '0;
            disp_digits <= '0;
            disp_en     <= '0;
            disp_dp     <= '0;
            anode_o     <= ANODE_ACTIVE_LOW ? '1 : '0;
            segments_o  <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
            dp_o        <= SEG_ACTIVE_LOW;
            frame_o     <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                t <= t + 4'd1;
                if (t == 4'hF) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            if (load_i) begin
                pend_digits <= digits_i;
                pend_en     <= digit_en_i;
                pend_dp     <= dp_i;
            end
            if (frame_wrap) begin
                disp_digits <= load_i ? digits_i   : pend_digits;
                disp_en     <= load_i ? digit_en_i : pend_en;
                disp_dp     <= load_i ? dp_i       : pend_dp;
            end
            anode_o    <= ANODE_ACTIVE_LOW ? ~anode_ah : anode_ah;
            segments_o <= SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
            dp_o       <= SEG_ACTIVE_LOW ? ~dp_ah : dp_ah;
            frame_o    <= frame_wrap;
        end
    end

endmodule
